// File: rtl/ibus_fetch_ctrl_pkg.sv
// ibus_fetch_ctrl_pkg: shared types for the instruction-bus fetch controller.
package ibus_fetch_ctrl_pkg;
  typedef logic [31:0] word_t;
  typedef enum logic [2:0] {IDLE, REQ, WAIT, DONE, DISCARD} fetch_ctrl_state_t;
  localparam logic [15:0] DISCARD_MAX = 16'hFFFF;
endpackage

// File: rtl/ibus_fetch_ctrl.sv
// ibus_fetch_ctrl: issues one aligned ibus read per fetch PC, forwards data, drops stale responses.
module ibus_fetch_ctrl
  import ibus_fetch_ctrl_pkg::*;
#(
  parameter int DATA_W     = 64,
  parameter int ALIGN_BITS = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  word_t             pc_in,
  input  logic              pc_valid,
  input  logic              stall,
  input  logic              flush,
  output logic              pc_accept,
  output logic              fetch_busy,
  output logic              ibus_req,
  output word_t             ibus_addr,
  input  logic              ibus_addr_ok,
  input  logic              ibus_data_ok,
  input  logic [DATA_W-1:0] ibus_rdata,
  output logic              inst_ibus_data_ok,
  output logic [DATA_W-1:0] inst_ibus_data,
  output logic              inst_ibus_index,
  output logic [15:0]       discard_cnt
);
  fetch_ctrl_state_t state_q, state_d;
  word_t pc_q, pc_d;
  logic [15:0] cnt_q, cnt_d;
  logic acc, take, dok, unused_pc_bits;
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    cnt_d    = cnt_q;
    take     = 1'b0;
    dok      = 1'b0;
    ibus_req = 1'b0;
    acc      = pc_valid & ~stall & ~flush;
    case (state_q)
      IDLE: take = acc;
      REQ: begin
        ibus_req = 1'b1;
        if (ibus_addr_ok) state_d = flush ? DISCARD : WAIT;
        else if (flush) state_d = IDLE;
      end
      WAIT: begin
        if (ibus_data_ok) begin
          dok     = ~flush;
          take    = acc;
          state_d = (~flush & stall) ? DONE : IDLE;
        end else if (flush) state_d = DISCARD;
      end
      DONE: begin
        take = acc;
        if (flush | (~stall & ~pc_valid)) state_d = IDLE;
      end
      DISCARD: begin
        // exactly one response is owed here, so flush cannot shorten the wait
        if (ibus_data_ok) begin
          state_d = IDLE;
          cnt_d   = cnt_q + {15'd0, cnt_q != DISCARD_MAX};
        end
      end
      default: state_d = IDLE;
    endcase
    if (take) begin
      pc_d    = pc_in;
      state_d = REQ;
    end
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      pc_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
    end
  end
  assign pc_accept         = take & reset;
  assign inst_ibus_data_ok = dok & reset;
  assign fetch_busy        = state_q != IDLE;
  assign ibus_addr         = {pc_q[31:ALIGN_BITS], {ALIGN_BITS{1'b0}}};
  assign inst_ibus_data    = ibus_rdata;
  assign inst_ibus_index   = pc_q[2];
  assign discard_cnt       = cnt_q;
  assign unused_pc_bits    = ^pc_q[1:0];
endmodule

// File: tb/tb_ibus_fetch_ctrl.sv
// tb_ibus_fetch_ctrl: directed scenarios plus randomized traffic against a transaction-level model.
module tb_ibus_fetch_ctrl;
  import ibus_fetch_ctrl_pkg::*;
  logic clk = 1'b0;
  logic reset = 1'b0;
  word_t pc_in = '0;
  logic pc_valid = 1'b0, stall = 1'b0, flush = 1'b0, ibus_addr_ok = 1'b0, ibus_data_ok = 1'b0;
  logic [63:0] ibus_rdata = 64'hDEADBEEF_01234567;
  logic pc_accept, fetch_busy, ibus_req, inst_ibus_data_ok, inst_ibus_index;
  word_t ibus_addr;
  logic [63:0] inst_ibus_data;
  logic [15:0] discard_cnt;
  int checks = 0, errors = 0;

  ibus_fetch_ctrl dut (
    .clk(clk), .reset(reset), .pc_in(pc_in), .pc_valid(pc_valid), .stall(stall), .flush(flush),
    .pc_accept(pc_accept), .fetch_busy(fetch_busy), .ibus_req(ibus_req), .ibus_addr(ibus_addr),
    .ibus_addr_ok(ibus_addr_ok), .ibus_data_ok(ibus_data_ok), .ibus_rdata(ibus_rdata),
    .inst_ibus_data_ok(inst_ibus_data_ok), .inst_ibus_data(inst_ibus_data),
    .inst_ibus_index(inst_ibus_index), .discard_cnt(discard_cnt)
  );

  always #5 clk = ~clk;

  // Transaction-level model: an open request, an owed response (maybe stale), delivered-but-held data.
  logic m_req = 1'b0, m_owed = 1'b0, m_stale = 1'b0, m_hold = 1'b0;
  word_t m_pc = '0;
  int m_cnt = 0;
  logic e_busy, e_dok, e_acc, e_idx;
  word_t e_addr;
  always_comb begin
    e_busy = m_req | m_owed | m_hold;
    e_dok  = reset & m_owed & !m_stale & ibus_data_ok & !flush;
    e_acc  = reset & pc_valid & !stall & !flush & (!e_busy | m_hold | (m_owed & !m_stale & ibus_data_ok));
    e_addr = m_pc & 32'hFFFF_FFF8;
    e_idx  = m_pc[2];
  end
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_req <= 0; m_owed <= 0; m_stale <= 0; m_hold <= 0; m_pc <= '0; m_cnt <= 0;
    end else begin
      if (m_req) begin
        if (ibus_addr_ok) begin
          m_req <= 0; m_owed <= 1; m_stale <= flush;
        end else if (flush) m_req <= 0;
      end else if (m_owed) begin
        if (ibus_data_ok) begin
          m_owed <= 0; m_stale <= 0;
          if (m_stale) m_cnt <= (m_cnt < 65535) ? m_cnt + 1 : m_cnt;
          else if (!flush && !e_acc && stall) m_hold <= 1;
        end else if (flush) m_stale <= 1;
      end else if (m_hold && (flush || e_acc || (!stall && !pc_valid))) m_hold <= 0;
      if (e_acc) begin
        m_pc <= pc_in; m_req <= 1; m_hold <= 0;
      end
    end
  end

  task automatic drive(input logic v, input word_t pc, input logic st, input logic fl,
                       input logic ao, input logic dk, input logic [63:0] rd);
    @(negedge clk);
    pc_valid = v; pc_in = pc; stall = st; flush = fl;
    ibus_addr_ok = ao; ibus_data_ok = dk; ibus_rdata = rd;
    #1;
  endtask

  task automatic idle();
    drive(0, '0, 0, 0, 0, 0, 64'h0);
  endtask

  task automatic test_reset();
    pc_valid = 1'b1; pc_in = 32'h1234_5678;
    #2;
    checks++;
    if ({ibus_req, pc_accept, fetch_busy, inst_ibus_data_ok, inst_ibus_index} !== 5'b0) begin
      errors++; $display("FAIL reset_ctrl req/acc/busy/dok/idx=%b exp=00000",
        {ibus_req, pc_accept, fetch_busy, inst_ibus_data_ok, inst_ibus_index});
    end
    checks++;
    if (ibus_addr !== 32'h0 || discard_cnt !== 16'h0) begin
      errors++; $display("FAIL reset_regs addr=%h cnt=%h exp=0/0", ibus_addr, discard_cnt);
    end
    checks++;
    if (inst_ibus_data !== 64'hDEADBEEF_01234567) begin
      errors++; $display("FAIL reset_data data=%h exp=deadbeef01234567", inst_ibus_data);
    end
    @(negedge clk);
    pc_valid = 1'b0;
    reset = 1'b1;
  endtask

  task automatic test_basic_fetch();
    drive(1, 32'hBFC00000, 0, 0, 0, 0, 64'h0);
    checks++;
    if (pc_accept !== 1'b1) begin errors++; $display("FAIL basic_accept pc_accept=%b exp=1", pc_accept); end
    idle();
    checks++;
    if (ibus_req !== 1'b1 || ibus_addr !== 32'hBFC00000) begin
      errors++; $display("FAIL basic_req req=%b addr=%h exp=1/bfc00000", ibus_req, ibus_addr);
    end
    drive(0, '0, 0, 0, 1, 0, 64'h0);
    idle();
    checks++;
    if (ibus_req !== 1'b0 || fetch_busy !== 1'b1 || inst_ibus_data_ok !== 1'b0) begin
      errors++; $display("FAIL basic_wait req=%b busy=%b dok=%b exp=0/1/0", ibus_req, fetch_busy, inst_ibus_data_ok);
    end
    idle();
    drive(0, '0, 0, 0, 0, 1, 64'h24020001_24010001);
    checks++;
    if (inst_ibus_data_ok !== 1'b1 || inst_ibus_data !== 64'h24020001_24010001 || inst_ibus_index !== 1'b0) begin
      errors++; $display("FAIL basic_data dok=%b data=%h idx=%b exp=1/2402000124010001/0",
        inst_ibus_data_ok, inst_ibus_data, inst_ibus_index);
    end
    idle();
    checks++;
    if (inst_ibus_data_ok !== 1'b0 || fetch_busy !== 1'b0) begin
      errors++; $display("FAIL basic_after dok=%b busy=%b exp=0/0", inst_ibus_data_ok, fetch_busy);
    end
  endtask

  task automatic test_odd_word();
    drive(1, 32'hBFC00004, 0, 0, 0, 0, 64'h0);
    idle();
    checks++;
    if (ibus_addr !== 32'hBFC00000 || inst_ibus_index !== 1'b1) begin
      errors++; $display("FAIL odd_addr addr=%h idx=%b exp=bfc00000/1", ibus_addr, inst_ibus_index);
    end
    drive(0, '0, 0, 0, 1, 0, 64'h0);
    drive(0, '0, 0, 0, 0, 1, 64'h11112222_33334444);
    checks++;
    if (inst_ibus_data_ok !== 1'b1 || inst_ibus_index !== 1'b1) begin
      errors++; $display("FAIL odd_data dok=%b idx=%b exp=1/1", inst_ibus_data_ok, inst_ibus_index);
    end
  endtask

  task automatic test_flush_wait();
    drive(1, 32'h00001000, 0, 0, 0, 0, 64'h0);
    drive(0, '0, 0, 0, 1, 0, 64'h0);
    drive(0, '0, 0, 1, 0, 0, 64'h0);
    checks++;
    if (inst_ibus_data_ok !== 1'b0 || ibus_req !== 1'b0) begin
      errors++; $display("FAIL flush_cycle dok=%b req=%b exp=0/0", inst_ibus_data_ok, ibus_req);
    end
    for (int i = 0; i < 2; i++) begin
      drive(1, 32'h80000100, 0, i == 1, 0, 0, 64'h0);
      checks++;
      if (pc_accept !== 1'b0 || ibus_req !== 1'b0 || fetch_busy !== 1'b1) begin
        errors++; $display("FAIL discard_hold acc=%b req=%b busy=%b exp=0/0/1", pc_accept, ibus_req, fetch_busy);
      end
    end
    drive(1, 32'h80000100, 0, 0, 0, 1, 64'hAAAA_BBBB_CCCC_DDDD);
    checks++;
    if (inst_ibus_data_ok !== 1'b0 || pc_accept !== 1'b0) begin
      errors++; $display("FAIL discard_drop dok=%b acc=%b exp=0/0", inst_ibus_data_ok, pc_accept);
    end
    drive(1, 32'h80000100, 0, 0, 0, 0, 64'h0);
    checks++;
    if (discard_cnt !== 16'd1 || pc_accept !== 1'b1) begin
      errors++; $display("FAIL discard_cnt cnt=%0d acc=%b exp=1/1", discard_cnt, pc_accept);
    end
    idle();
    checks++;
    if (ibus_req !== 1'b1 || ibus_addr !== 32'h80000100) begin
      errors++; $display("FAIL discard_next req=%b addr=%h exp=1/80000100", ibus_req, ibus_addr);
    end
    drive(0, '0, 0, 0, 1, 0, 64'h0);
    drive(0, '0, 0, 0, 0, 1, 64'h0);
  endtask

  task automatic test_stall();
    drive(1, 32'h00002008, 0, 0, 0, 0, 64'h0);
    drive(0, '0, 0, 0, 1, 0, 64'h0);
    drive(0, '0, 1, 0, 0, 1, 64'h55556666_77778888);
    checks++;
    if (inst_ibus_data_ok !== 1'b1 || pc_accept !== 1'b0) begin
      errors++; $display("FAIL stall_data dok=%b acc=%b exp=1/0", inst_ibus_data_ok, pc_accept);
    end
    for (int i = 0; i < 2; i++) begin
      drive(1, 32'h00003000, 1, 0, 0, 0, 64'h0);
      checks++;
      if (ibus_req !== 1'b0 || inst_ibus_data_ok !== 1'b0 || fetch_busy !== 1'b1 || pc_accept !== 1'b0) begin
        errors++; $display("FAIL stall_done req=%b dok=%b busy=%b acc=%b exp=0/0/1/0",
          ibus_req, inst_ibus_data_ok, fetch_busy, pc_accept);
      end
    end
    drive(1, 32'h00003000, 0, 0, 0, 0, 64'h0);
    checks++;
    if (pc_accept !== 1'b1) begin errors++; $display("FAIL stall_release acc=%b exp=1", pc_accept); end
    idle();
    checks++;
    if (ibus_req !== 1'b1 || ibus_addr !== 32'h00003000) begin
      errors++; $display("FAIL stall_next req=%b addr=%h exp=1/00003000", ibus_req, ibus_addr);
    end
    drive(0, '0, 0, 0, 1, 0, 64'h0);
    drive(0, '0, 0, 0, 0, 1, 64'h0);
  endtask

  task automatic test_back_to_back();
    drive(1, 32'h00004000, 0, 0, 0, 0, 64'h0);
    drive(0, '0, 0, 0, 1, 0, 64'h0);
    drive(1, 32'h00004010, 0, 0, 0, 1, 64'h0);
    checks++;
    if (pc_accept !== 1'b1 || inst_ibus_data_ok !== 1'b1) begin
      errors++; $display("FAIL b2b_accept acc=%b dok=%b exp=1/1", pc_accept, inst_ibus_data_ok);
    end
    idle();
    checks++;
    if (ibus_req !== 1'b1 || ibus_addr !== 32'h00004010) begin
      errors++; $display("FAIL b2b_req req=%b addr=%h exp=1/00004010", ibus_req, ibus_addr);
    end
    drive(0, '0, 0, 0, 1, 0, 64'h0);
    drive(0, '0, 0, 0, 0, 1, 64'h0);
  endtask

  task automatic test_withdraw();
    logic [15:0] c;
    c = discard_cnt;
    drive(1, 32'h00005000, 0, 0, 0, 0, 64'h0);
    drive(0, '0, 0, 1, 0, 0, 64'h0);
    checks++;
    if (ibus_req !== 1'b1) begin errors++; $display("FAIL withdraw_req req=%b exp=1", ibus_req); end
    idle();
    checks++;
    if (fetch_busy !== 1'b0 || ibus_req !== 1'b0 || discard_cnt !== c) begin
      errors++; $display("FAIL withdraw_idle busy=%b req=%b cnt=%0d exp=0/0/%0d", fetch_busy, ibus_req, discard_cnt, c);
    end
  endtask

  task automatic test_reset_mid();
    drive(1, 32'h00006004, 0, 0, 0, 0, 64'h0);
    drive(0, '0, 0, 0, 1, 0, 64'h0);
    idle();
    @(negedge clk);
    reset = 1'b0;
    #1;
    checks++;
    if ({ibus_req, pc_accept, fetch_busy, inst_ibus_data_ok, inst_ibus_index} !== 5'b0 ||
        ibus_addr !== 32'h0 || discard_cnt !== 16'h0) begin
      errors++; $display("FAIL reset_mid ctrl=%b addr=%h cnt=%0d exp=00000/0/0",
        {ibus_req, pc_accept, fetch_busy, inst_ibus_data_ok, inst_ibus_index}, ibus_addr, discard_cnt);
    end
    drive(0, '0, 0, 0, 0, 1, 64'h0);
    @(negedge clk);
    reset = 1'b1;
    drive(0, '0, 0, 0, 0, 1, 64'h0);
    checks++;
    if (inst_ibus_data_ok !== 1'b0 || fetch_busy !== 1'b0) begin
      errors++; $display("FAIL reset_stray dok=%b busy=%b exp=0/0", inst_ibus_data_ok, fetch_busy);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 800; n++) begin
      drive($urandom_range(0, 1), $urandom, $urandom_range(0, 3) == 0, $urandom_range(0, 9) == 0,
            $urandom_range(0, 1), $urandom_range(0, 2) == 0, {$urandom, $urandom});
      checks++;
      if (pc_accept !== e_acc || ibus_req !== m_req || fetch_busy !== e_busy || inst_ibus_data_ok !== e_dok) begin
        errors++; $display("FAIL rand_ctrl n=%0d acc/req/busy/dok=%b%b%b%b exp=%b%b%b%b", n,
          pc_accept, ibus_req, fetch_busy, inst_ibus_data_ok, e_acc, m_req, e_busy, e_dok);
      end
      checks++;
      if (ibus_addr !== e_addr || inst_ibus_index !== e_idx || inst_ibus_data !== ibus_rdata) begin
        errors++; $display("FAIL rand_data n=%0d addr=%h idx=%b exp=%h/%b", n, ibus_addr, inst_ibus_index, e_addr, e_idx);
      end
      checks++;
      if (discard_cnt !== m_cnt[15:0]) begin
        errors++; $display("FAIL rand_cnt n=%0d cnt=%0d exp=%0d", n, discard_cnt, m_cnt);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic_fetch();
    test_odd_word();
    test_flush_wait();
    test_stall();
    test_back_to_back();
    test_withdraw();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
